fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch/execute sequencer for the R3 core. It owns the architectural PC, fetches each instruction from instruction memory over a request/grant/response handshake, and holds the instruction in an instruction register for the decode/control path. It gates register-file writes so each instruction writes exactly once, and it advances the PC by +4 or by the branch immediate. It sits between instruction memory and the control/decode logic, and replaces the free-running combinational ROM fetch.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- DATA_WIDTH, 32: PC, instruction and immediate width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; when low, the sequencer parks in IDLE at the next instruction boundary.
- imem_req  out  1  fetch request; held until granted.
- imem_addr  out  32  fetch address; equals PC while imem_req is high.
- imem_gnt  in  1  memory accepts the request in this cycle.
- imem_rvalid  in  1  instruction data valid; asserted at least 1 cycle after the grant.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register, feeding decode.
- pc  out  32  PC of the instruction held in instr.
- PCsrc  in  1  branch taken, from the control unit.
- ImmOp  in  32  sign-extended immediate, from the control unit.
- RegWrite  in  1  decoded register-write request.
- reg_we  out  1  gated register-file write enable.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction count.
- fault  out  1  sticky misaligned-PC flag.
- busy  out  1  high in every state except IDLE and FAULT.

## Operation

- States: IDLE, REQ, WAIT, EXEC, FAULT.
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0. All other outputs are 0.
- IDLE:
  - imem_req=0.
  - If en is high, go to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - If imem_gnt is high, go to WAIT; otherwise stay, holding req and addr stable.
- WAIT:
  - On imem_rvalid, load instr<=imem_rdata and go to EXEC.
  - There is no timeout.
- EXEC, exactly one cycle:
  - reg_we=RegWrite and retire=1.
  - instret<=instret+1; it wraps from 2^32-1 to 0.
  - next_pc = PCsrc ? pc+ImmOp : pc+4, computed mod 2^32.
  - If next_pc[1:0] is not 0: pc is left unchanged, go to FAULT.
  - Otherwise pc<=next_pc, and go to REQ if en is high, else IDLE.
- FAULT:
  - fault=1 and imem_req=0.
  - FAULT is terminal; only rst_n exits it.
- reg_we is 0 in every state other than EXEC, whatever the value of RegWrite.
- imem_rvalid outside WAIT is ignored. imem_gnt outside REQ is ignored.
- Only one fetch is outstanding at a time.
- en going low mid-instruction: the current instruction completes through EXEC, then the sequencer parks in IDLE.
- Reset mid-fetch: the sequencer returns to IDLE immediately. The memory is reset in the same reset domain, so there are no stale responses.
- instr and pc hold their values in IDLE and FAULT.

## Timing

- Minimum is 3 cycles per instruction: REQ (grant in the same cycle), WAIT (rvalid on the next cycle), EXEC.
- Each extra cycle of grant or response latency adds 1 cycle.
- instr, pc and reg_we are valid during the EXEC cycle. The register file samples reg_we on the EXEC rising edge.
- pc and instret update on the edge that leaves EXEC.
- In the cycle after EXEC, pc already holds the next fetch address.
- From en rising in IDLE, imem_req is asserted on the next cycle.
- All outputs are registered or decoded from state only. There is no combinational path from imem_* inputs to imem_req.

## Structure

- Shared package seq_pkg holds:
  - the seq_state_t enum (IDLE, REQ, WAIT, EXEC, FAULT);
  - the NOP_INSTR constant (32'h0000_0013);
  - the PC_INC constant (4).
- The block is a single flat module with no sub-modules.
- The next-PC adder is inline; ImmOp arrives already extended.

## Test plan

- Reset release with en=1, gnt=1 immediate, rvalid 1 cycle later, RegWrite=1, PCsrc=0 for 4 instructions → addresses 0x0, 0x4, 0x8, 0xC are fetched; retire pulses every 3 cycles; instret=4; reg_we is high exactly 4 cycles.
- gnt delayed 2 cycles and rvalid delayed 3 cycles → imem_req and imem_addr stay stable while ungranted; 7 cycles per instruction; no duplicate reg_we.
- Branch at pc=0x10 with PCsrc=1 and ImmOp=0xFFFF_FFF8 → next fetch is at 0x08. Then ImmOp=0x6 taken → fault=1, pc stays at the branch address, imem_req stays at 0 indefinitely.
- en dropped during WAIT → the instruction completes (retire=1 once), then IDLE with busy=0. en raised again → fetch resumes from the next pc.
- rst_n asserted during WAIT at pc=0x20 → outputs go to reset values at once; after release, the fetch starts at RESET_PC; instret=0.
- instret preloaded via force to 0xFFFF_FFFF, then one retire → instret=0; spurious rvalid injected in REQ → ignored, and instr is unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the R3 fetch/execute sequencer.
package seq_pkg;

   localparam int unsigned INSTRET_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      EXEC  = 3'd3,
      FAULT = 3'd4
   } seq_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over a req/gnt/rvalid
// handshake, holds the instruction register and gates one register write per instruction.
module fetch_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  RegWrite,
   output logic                  reg_we,
   output logic                  retire,
   output logic [INSTRET_W-1:0]  instret,
   output logic                  fault,
   output logic                  busy
);

   seq_state_t            state;
   seq_state_t            state_nxt;
   logic [DATA_WIDTH-1:0] next_pc_c;
   logic                  misaligned_c;

   // Next-PC adder; a misaligned target parks the core in FAULT.
   assign next_pc_c    = PCsrc ? (pc + ImmOp) : (pc + DATA_WIDTH'(PC_INC));
   assign misaligned_c = |next_pc_c[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus outputs decoded from state only (reg_we also qualifies RegWrite).
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      imem_addr = '0;
      reg_we    = 1'b0;
      retire    = 1'b0;
      fault     = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (en) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            imem_req  = 1'b1;
            imem_addr = pc;
            if (imem_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            reg_we = RegWrite;
            retire = 1'b1;
            if (misaligned_c) begin
               state_nxt = FAULT;
            end else if (en) begin
               state_nxt = REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         FAULT: begin
            busy  = 1'b0;
            fault = 1'b1;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Architectural registers: instr loads on response, pc/instret move when leaving EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         instr   <= DATA_WIDTH'(NOP_INSTR);
         instret <= '0;
      end else begin
         if ((state == WAIT) && imem_rvalid) begin
            instr <= imem_rdata;
         end
         if (state == EXEC) begin
            instret <= instret + INSTRET_W'(1);
            if (!misaligned_c) begin
               pc <= next_pc_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: handshake-level reference model checked every
// cycle, plus directed scenarios pinned with hand-computed literals.
`timescale 1ns/1ps
module tb_fetch_sequencer;
   import seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        PCsrc = 1'b0;
   logic [31:0] ImmOp = 32'h0;
   logic        RegWrite = 1'b0;
   logic        reg_we;
   logic        retire;
   logic [31:0] instret;
   logic        fault;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr(instr), .pc(pc), .PCsrc(PCsrc), .ImmOp(ImmOp), .RegWrite(RegWrite),
      .reg_we(reg_we), .retire(retire), .instret(instret), .fault(fault), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state plus handshake bookkeeping.
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_instr = NOP_INSTR;
   logic [31:0] m_instret = 32'h0;
   logic [31:0] m_nxt;
   bit m_fault = 0, m_out = 0, m_exec = 0, m_req_hold = 0, m_req_due = 0;
   bit exp_req, m_idle;
   int cyc = 0;
   int we_cnt = 0;
   logic [31:0] fetch_log[$];
   int retire_cyc[$];

   initial begin : compare
      forever begin
         @(negedge clk);
         cyc++;
         if (reg_we) we_cnt++;
         if (retire) retire_cyc.push_back(cyc);
         if (imem_req && imem_gnt) fetch_log.push_back(imem_addr);
         if (!rst_n) begin
            m_pc = 32'h0; m_instr = NOP_INSTR; m_instret = 32'h0;
            m_fault = 0; m_out = 0; m_exec = 0; m_req_hold = 0; m_req_due = 0;
            check("rst imem_req", 32'(imem_req), 0);
            check("rst imem_addr", imem_addr, 0);
            check("rst reg_we", 32'(reg_we), 0);
            check("rst retire", 32'(retire), 0);
            check("rst fault", 32'(fault), 0);
            check("rst busy", 32'(busy), 0);
            check("rst pc", pc, 32'h0);
            check("rst instr", instr, NOP_INSTR);
            check("rst instret", instret, 0);
         end else begin
            exp_req = m_req_hold || m_req_due;
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("imem_addr", imem_addr, m_pc);
            check("retire", 32'(retire), 32'(m_exec));
            check("reg_we", 32'(reg_we), 32'(m_exec && RegWrite));
            check("busy", 32'(busy), 32'(!m_fault && (exp_req || m_out || m_exec)));
            check("fault", 32'(fault), 32'(m_fault));
            check("pc", pc, m_pc);
            check("instr", instr, m_instr);
            check("instret", instret, m_instret);
            m_idle = !m_fault && !exp_req && !m_out && !m_exec;
            m_req_due = 0;
            if (m_exec) begin
               m_instret = m_instret + 1;
               m_nxt = PCsrc ? m_pc + ImmOp : m_pc + 32'd4;
               if (m_nxt[1:0] != 2'b00) m_fault = 1;
               else begin
                  m_pc = m_nxt;
                  m_req_due = en;
               end
               m_exec = 0;
            end else if (m_idle && en) begin
               m_req_due = 1;
            end
            m_req_hold = exp_req && !imem_gnt;
            if (m_out && imem_rvalid) begin
               m_out = 0; m_exec = 1; m_instr = imem_rdata;
            end
            if (exp_req && imem_gnt) m_out = 1;
         end
      end
   end

   // Memory responder and control-unit stand-in, driven #1 after each rising edge.
   int cfg_g = 0, cfg_r = 1;
   bit cfg_rand = 0, cfg_spur = 0;
   logic cfg_rw = 1'b1, cfg_br = 1'b0;
   logic [31:0] cfg_imm = 32'h0;
   bit r_pend = 0, r_exec = 0, r_inreq = 0, exec_now;
   int g_wait = 0, r_wait = 0, k;

   initial begin : responder
      forever begin
         @(posedge clk); #1;
         imem_gnt = 1'b0; imem_rvalid = 1'b0;
         exec_now = r_exec; r_exec = 0;
         if (exec_now) begin
            if (cfg_rand) begin
               RegWrite = 1'($urandom);
               PCsrc    = ($urandom_range(0, 3) == 0);
               k        = int'($urandom_range(0, 32)) - 16;
               ImmOp    = 32'(k * 4);
            end else begin
               RegWrite = cfg_rw; PCsrc = cfg_br; ImmOp = cfg_imm;
            end
         end else begin
            RegWrite = 1'($urandom); PCsrc = 1'($urandom); ImmOp = $urandom;
         end
         if (!rst_n) begin
            r_pend = 0; r_inreq = 0;
         end else if (r_pend) begin
            if (r_wait == 0) begin
               imem_rvalid = 1'b1; imem_rdata = $urandom; r_pend = 0; r_exec = 1;
            end else begin
               r_wait--;
               if (cfg_spur) imem_gnt = 1'b1;
            end
         end else if (imem_req) begin
            if (!r_inreq) begin
               r_inreq = 1;
               g_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_g;
            end
            if (g_wait == 0) begin
               imem_gnt = 1'b1; r_pend = 1; r_inreq = 0;
               r_wait = (cfg_rand ? int'($urandom_range(1, 4)) : cfg_r) - 1;
            end else begin
               g_wait--;
               if (cfg_spur) begin
                  imem_rvalid = 1'b1; imem_rdata = $urandom;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_fetches(input int n, input int budget);
      int c = 0;
      while (fetch_log.size() < n && c < budget) begin
         tick(1); c++;
      end
      check("fetch wait timeout", 32'(fetch_log.size() >= n), 1);
   endtask

   task automatic wait_retires(input int n, input int budget);
      int c = 0;
      while (retire_cyc.size() < n && c < budget) begin
         tick(1); c++;
      end
      check("retire wait timeout", 32'(retire_cyc.size() >= n), 1);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   int we_base;

   initial begin : main
      tick(3);
      check("reset pc", pc, 32'h0);
      check("reset instr", instr, 32'h0000_0013);

      // Back-to-back sequential fetches, en dropped during the 4th WAIT.
      we_base = we_cnt; fetch_log.delete(); retire_cyc.delete();
      rst_n = 1'b1; en = 1'b1;
      wait_fetches(4, 100);
      en = 1'b0;
      wait_retires(4, 50);
      tick(3);
      check("t1 addr0", fetch_log[0], 32'h0);
      check("t1 addr1", fetch_log[1], 32'h4);
      check("t1 addr2", fetch_log[2], 32'h8);
      check("t1 addr3", fetch_log[3], 32'hC);
      for (int i = 1; i < 4; i++) check("t1 retire period", 32'(retire_cyc[i] - retire_cyc[i-1]), 3);
      check("t1 retires", 32'(retire_cyc.size()), 4);
      check("t1 instret", instret, 4);
      check("t1 reg_we cycles", 32'(we_cnt - we_base), 4);
      check("t1 parked busy", 32'(busy), 0);

      // Resume with backward branch, then slow memory with spurious handshakes.
      we_base = we_cnt; fetch_log.delete(); retire_cyc.delete();
      cfg_g = 2; cfg_r = 3; cfg_spur = 1; cfg_br = 1'b1; cfg_imm = 32'hFFFF_FFF8;
      en = 1'b1;
      wait_retires(1, 50);
      cfg_br = 1'b0;
      wait_fetches(3, 100);
      en = 1'b0;
      wait_retires(3, 50);
      tick(3);
      check("t2 addr0", fetch_log[0], 32'h10);
      check("t2 branch target", fetch_log[1], 32'h08);
      check("t2 addr2", fetch_log[2], 32'h0C);
      check("t2 period a", 32'(retire_cyc[1] - retire_cyc[0]), 7);
      check("t2 period b", 32'(retire_cyc[2] - retire_cyc[1]), 7);
      check("t2 instret", instret, 7);
      check("t2 reg_we cycles", 32'(we_cnt - we_base), 3);
      check("t2 pc", pc, 32'h10);

      // Random latencies, branches, RegWrite and en toggling.
      cfg_rand = 1;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 7) != 0);
         tick(1);
      end
      en = 1'b0;
      tick(30);
      check("t3 drained busy", 32'(busy), 0);
      check("t3 no fault", 32'(fault), 0);

      // Reset asserted in WAIT of the fetch at 0x20.
      cfg_rand = 0; cfg_spur = 0; cfg_g = 0; cfg_r = 3; cfg_br = 1'b0; cfg_rw = 1'b1;
      rst_n = 1'b0; tick(2);
      fetch_log.delete(); retire_cyc.delete();
      rst_n = 1'b1; en = 1'b1;
      wait_fetches(9, 200);
      check("t4 addr before reset", fetch_log[8], 32'h20);
      rst_n = 1'b0;
      #1;
      check("t4 async pc", pc, 32'h0);
      check("t4 async instret", instret, 0);
      check("t4 async instr", instr, 32'h0000_0013);
      check("t4 async busy", 32'(busy), 0);
      tick(2);
      fetch_log.delete(); retire_cyc.delete();
      rst_n = 1'b1;
      wait_fetches(1, 20);
      check("t4 restart addr", fetch_log[0], 32'h0);
      check("t4 restart instret", instret, 0);

      // Misaligned branch at 0x4 -> terminal FAULT.
      wait_fetches(2, 50);
      cfg_br = 1'b1; cfg_imm = 32'h0000_0006;
      wait_retires(2, 50);
      tick(2);
      check("t5 fault", 32'(fault), 1);
      check("t5 pc held", pc, 32'h4);
      check("t5 instret", instret, 2);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("t5 req stays low", 32'(imem_req), 0);
      end

      // instret wrap, with spurious rvalid while ungranted.
      cfg_br = 1'b0; cfg_g = 1; cfg_r = 2; cfg_spur = 1;
      en = 1'b0; rst_n = 1'b0; tick(2);
      rst_n = 1'b1; tick(2);
      force dut.instret = 32'hFFFF_FFFF;
      m_instret = 32'hFFFF_FFFF;
      tick(1);
      release dut.instret;
      tick(1);
      check("t6 preload", instret, 32'hFFFF_FFFF);
      fetch_log.delete(); retire_cyc.delete();
      en = 1'b1;
      wait_fetches(1, 20);
      en = 1'b0;
      wait_retires(1, 20);
      tick(2);
      check("t6 instret wrap", instret, 32'h0);
      check("t6 pc", pc, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
